div_unit: RTL

- Multi-cycle integer divider in the execute stage, directly downstream of the decode-stage control unit.
- Consumes the 3-bit divsel code (001 div, 010 divu, 011 rem, 100 remu) and the ID/EX operands; implements RISC-V M-extension DIV/DIVU/REM/REMU semantics.
- Uses a radix-2 restoring algorithm and asserts a stall request to hold the pipeline while an operation runs.

---
 rtl/div_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring integer divider (RISC-V DIV/DIVU/REM/REMU)
//
// Purpose: execute-stage divider. It accepts a divsel code from decode and the
// ID/EX operands. It holds the pipeline through stall_req while it iterates.
// Divide-by-zero and signed overflow complete on a fast path that skips CALC.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      division instruction valid in EX this cycle
//   divsel     001 div, 010 divu, 011 rem, 100 remu; other codes ignored
//   dividend   rs1 operand
//   divisor    rs2 operand
//   flush      synchronous kill of any in-flight operation
//   stall_req  combinational pipeline hold request
//   busy       registered, high in CALC/FIX
//   done       registered one-cycle completion pulse
//   result     quotient or remainder, held until the next completion

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       divsel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_op_q, rem_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             op_valid, in_signed, in_rem, accept;
  logic             a_neg, b_neg, div_zero, overflow;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    op_valid  = (divsel >= 3'b001) && (divsel <= 3'b100);
    in_signed = (divsel == 3'b001) || (divsel == 3'b011);
    in_rem    = (divsel == 3'b011) || (divsel == 3'b100);
    accept    = (state_q == S_IDLE) && start && op_valid && !flush;

    a_neg    = in_signed && dividend[WIDTH-1];
    b_neg    = in_signed && divisor[WIDTH-1];
    a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero = (divisor == '0);
    overflow = in_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

    // The partial remainder never reaches the divisor, so it fits in WIDTH bits.
    // After the shift it needs one extra bit for the compare.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = shifted >= {1'b0, dvs_q};

    quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  assign stall_req = accept || (state_q == S_CALC) || (state_q == S_FIX);

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_op_d  = rem_op_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (div_zero || overflow) begin
            if (div_zero) result_d = in_rem ? dividend : '1;
            else          result_d = in_rem ? '0 : dividend;
            state_d = S_DONE;
          end else begin
            quo_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            cnt_d     = CNT_INIT;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            rem_op_d  = in_rem;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = rem_op_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_op_q  <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_op_q  <= rem_op_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule
